// File: rtl/morse_beep_scheduler.sv
// rtl/morse_beep_scheduler.sv - queued Morse symbol player driving the buzzer (MORSE_WORD_GAP_EN queues word spaces)
// Symbols are buffered in a small FIFO and sequenced as gated square-wave tone with standard Morse timing.
module morse_beep_scheduler #(
   parameter int UNIT_CYCLES = 20_000_000,
   parameter int TONE_DIV    = 50_000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_valid,
   output logic       sym_ready,
   input  logic [4:0] sym_code,
   input  logic [2:0] sym_len,
   input  logic       abort,
   output logic       busy,
   output logic [4:0] fifo_count,
   output logic       tone_on,
   output logic       beep
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int DW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
`ifdef MORSE_WORD_GAP_EN
   localparam int TW = $clog2(7 * UNIT_CYCLES + 1);
`else
   localparam int TW = $clog2(3 * UNIT_CYCLES + 1);
`endif

   localparam logic [TW-1:0] T_UNIT  = TW'(UNIT_CYCLES);
   localparam logic [TW-1:0] T_THREE = TW'(3 * UNIT_CYCLES);
`ifdef MORSE_WORD_GAP_EN
   localparam logic [TW-1:0] T_SEVEN = TW'(7 * UNIT_CYCLES);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_TONE, S_GAP, S_CGAP
`ifdef MORSE_WORD_GAP_EN
      , S_WGAP
`endif
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [4:0]    sh_q, sh_d;
   logic [2:0]    elem_q, elem_d;
   logic [4:0]    count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] div_q, div_d;
   logic          phase_q, phase_d;
   logic          beep_q, beep_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic       push, pop;
   logic [2:0] len_w, head_len;
   logic [4:0] head_code, head_sh;

   always_comb begin
      len_w     = (sym_len > 3'd5) ? 3'd5 : sym_len;
      sym_ready = rst & (count_q < 5'(FIFO_DEPTH)) & ~abort;
`ifdef MORSE_WORD_GAP_EN
      push      = sym_valid & sym_ready;
`else
      push      = sym_valid & sym_ready & (sym_len != 3'd0);
`endif
      head_len  = mem_q[rd_ptr_q][7:5];
      head_code = mem_q[rd_ptr_q][4:0];
      // left-align the code so the element playing next is always sh[4]
      head_sh   = head_code << (3'd5 - head_len);
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      sh_d    = sh_q;
      elem_d  = elem_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != 5'd0) state_d = S_FETCH;
         end
         S_FETCH: begin
            pop    = 1'b1;
            sh_d   = head_sh;
            elem_d = head_len;
            if (head_len == 3'd0) begin
`ifdef MORSE_WORD_GAP_EN
               state_d = S_WGAP;
               timer_d = T_SEVEN;
`else
               state_d = S_IDLE;
`endif
            end else begin
               state_d = S_TONE;
               timer_d = head_sh[4] ? T_THREE : T_UNIT;
            end
         end
         S_TONE: begin
            if (timer_q == TW'(1)) begin
               if (elem_q > 3'd1) begin
                  state_d = S_GAP;
                  timer_d = T_UNIT;
                  sh_d    = {sh_q[3:0], 1'b0};
                  elem_d  = elem_q - 3'd1;
               end else begin
                  state_d = S_CGAP;
                  timer_d = T_THREE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_GAP: begin
            if (timer_q == TW'(1)) begin
               state_d = S_TONE;
               timer_d = sh_q[4] ? T_THREE : T_UNIT;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`ifdef MORSE_WORD_GAP_EN
         S_CGAP, S_WGAP: begin
`else
         S_CGAP: begin
`endif
            if (timer_q == TW'(1)) state_d = (count_q != 5'd0) ? S_FETCH : S_IDLE;
            else                   timer_d = timer_q - TW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d = S_IDLE;
         pop     = 1'b0;
      end
   end

   always_comb begin
      count_d  = count_q;
      if (push & ~pop)      count_d = count_q + 5'd1;
      else if (~push & pop) count_d = count_q - 5'd1;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      if (abort) begin
         count_d  = 5'd0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   // tone phase restarts at every element so each one begins on the low half
   always_comb begin
      phase_d = phase_q;
      div_d   = div_q;
      if (state_d == S_TONE && state_q != S_TONE) begin
         phase_d = 1'b0;
         div_d   = '0;
      end else if (state_q == S_TONE) begin
         if (div_q == DW'(TONE_DIV - 1)) begin
            div_d   = '0;
            phase_d = ~phase_q;
         end else begin
            div_d = div_q + DW'(1);
         end
      end
      beep_d = (state_d == S_TONE) & phase_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         sh_q     <= '0;
         elem_q   <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         div_q    <= '0;
         phase_q  <= 1'b0;
         beep_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         sh_q     <= sh_d;
         elem_q   <= elem_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         div_q    <= div_d;
         phase_q  <= phase_d;
         beep_q   <= beep_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {len_w, sym_code};
   end

   assign tone_on    = (state_q == S_TONE);
   assign beep       = beep_q;
   assign busy       = (state_q != S_IDLE) | (count_q != 5'd0);
   assign fifo_count = count_q;

endmodule

// File: tb/tb_morse_beep_scheduler.sv
// tb/tb_morse_beep_scheduler.sv - randomized bench for morse_beep_scheduler against a timeline reference model
// The model expands each dequeued symbol into a per-cycle list of tone/silence/beep values.
module tb_morse_beep_scheduler;
   localparam int U  = 10;
   localparam int TD = 2;
   localparam int D  = 4;

   localparam logic [1:0] SIL = 2'd0, TON0 = 2'd1, FET = 2'd2, TON1 = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sym_valid = 1'b0;
   logic       sym_ready;
   logic [4:0] sym_code = '0;
   logic [2:0] sym_len = '0;
   logic       abort = 1'b0;
   logic       busy;
   logic [4:0] fifo_count;
   logic       tone_on;
   logic       beep;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mq[$];
   logic [1:0] tl[$];

   morse_beep_scheduler #(.UNIT_CYCLES(U), .TONE_DIV(TD), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
      .sym_code(sym_code), .sym_len(sym_len), .abort(abort), .busy(busy),
      .fifo_count(fifo_count), .tone_on(tone_on), .beep(beep)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // expand one queued symbol into its per-cycle timeline, first element from bit[len-1]
   task automatic append_symbol(input logic [7:0] s);
      int l;
      int dur;
      l = int'(s[7:5]);
      if (l == 0) begin
         for (int k = 0; k < 7 * U; k++) tl.push_back(SIL);
      end else begin
         for (int i = l - 1; i >= 0; i--) begin
            dur = s[i] ? 3 * U : U;
            for (int k = 0; k < dur; k++) tl.push_back(((k / TD) % 2) ? TON1 : TON0);
            if (i > 0) for (int k = 0; k < U; k++) tl.push_back(SIL);
         end
         for (int k = 0; k < 3 * U; k++) tl.push_back(SIL);
      end
   endtask

   task automatic model_edge(output logic acc);
      int cnt;
      logic [1:0] it;
      logic [2:0] lc;
      cnt = mq.size();
      acc = sym_valid && (cnt < D) && !abort;
      if (abort) begin
         mq.delete();
         tl.delete();
      end else begin
         if (tl.size() == 0) begin
            if (cnt > 0) tl.push_back(FET);
         end else begin
            it = tl.pop_front();
            if (it == FET) append_symbol(mq.pop_front());
            else if (tl.size() == 0 && cnt > 0) tl.push_back(FET);
         end
         lc = (sym_len > 3'd5) ? 3'd5 : sym_len;
`ifdef MORSE_WORD_GAP_EN
         if (acc) mq.push_back({lc, sym_code});
`else
         if (acc && sym_len != 3'd0) mq.push_back({lc, sym_code});
`endif
      end
   endtask

   // called at a negedge: check the current cycle, drive the next inputs, advance the model
   task automatic cycle(input logic v, input logic [4:0] c, input logic [2:0] l, input logic ab,
                        output logic acc);
      logic et, eb;
      et = (tl.size() != 0) && tl[0][0];
      eb = (tl.size() != 0) && (tl[0] == TON1);
      check_eq("tone_on", {31'b0, tone_on}, {31'b0, et});
      check_eq("beep", {31'b0, beep}, {31'b0, eb});
      check_eq("busy", {31'b0, busy}, {31'b0, (tl.size() != 0) || (mq.size() != 0)});
      check_eq("fifo_count", {27'b0, fifo_count}, mq.size());
      check_eq("sym_ready", {31'b0, sym_ready}, {31'b0, (mq.size() < D) && !abort});
      sym_valid = v;
      sym_code  = c;
      sym_len   = l;
      abort     = ab;
      model_edge(acc);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 3'd0, 1'b0, acc);
   endtask

   task automatic send(input logic [4:0] c, input logic [2:0] l);
      logic acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 2000) begin
         cycle(1'b1, c, l, 1'b0, acc);
         n++;
      end
      if (!acc) begin
         n_checks++;
         $display("FAIL send_timeout: symbol code %0d len %0d not accepted", c, l);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((tl.size() != 0 || mq.size() != 0) && n < budget) begin
         idle(1);
         n++;
      end
      if (tl.size() != 0 || mq.size() != 0) begin
         n_checks++;
         $display("FAIL wait_idle: model still busy after %0d cycles", budget);
      end
   endtask

   // reset pulse placed between clock edges; outputs must drop without waiting for an edge
   task automatic do_reset();
      sym_valid = 1'b0;
      abort     = 1'b0;
      #2 rst = 1'b0;
      #1;
      check_eq("rst_tone_on", {31'b0, tone_on}, 0);
      check_eq("rst_beep", {31'b0, beep}, 0);
      check_eq("rst_busy", {31'b0, busy}, 0);
      check_eq("rst_fifo_count", {27'b0, fifo_count}, 0);
      check_eq("rst_sym_ready", {31'b0, sym_ready}, 0);
      mq.delete();
      tl.delete();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic acc;
      logic pend_v;
      logic [4:0] pc;
      logic [2:0] pl;
      int rate;

      @(negedge clk);
      check_eq("reset_sym_ready", {31'b0, sym_ready}, 0);
      check_eq("reset_busy", {31'b0, busy}, 0);
      check_eq("reset_tone_on", {31'b0, tone_on}, 0);
      check_eq("reset_beep", {31'b0, beep}, 0);
      check_eq("reset_fifo_count", {27'b0, fifo_count}, 0);
      #2 rst = 1'b1;
      @(negedge clk);

      send(5'b00001, 3'd2);
      wait_idle(300);
      idle(3);

      send(5'b11111, 3'd5);
      for (int i = 0; i < 6; i++) send(5'($urandom), 3'($urandom_range(1, 5)));
      wait_idle(3000);

      send(5'b11111, 3'd7);
      wait_idle(400);

      send(5'b00000, 3'd1);
      send(5'b10101, 3'd0);
      send(5'b00000, 3'd1);
      wait_idle(400);

      send(5'b11111, 3'd5);
      for (int i = 0; i < 3; i++) send(5'($urandom), 3'($urandom_range(1, 5)));
      idle(5);
      cycle(1'b1, 5'b00111, 3'd3, 1'b1, acc);
      for (int i = 0; i < 4; i++) cycle(1'b1, 5'b00111, 3'd3, 1'b1, acc);
      idle(3);

      send(5'b11000, 3'd4);
      idle(6);
      do_reset();
      idle(3);

      pend_v = 1'b0;
      pc = '0;
      pl = '0;
      for (int ph = 0; ph < 2; ph++) begin
         rate = (ph == 0) ? 15 : 2;
         for (int n = 0; n < 4000; n++) begin
            if (!pend_v && $urandom_range(0, 99) < rate) begin
               pend_v = 1'b1;
               pc = 5'($urandom);
               pl = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 2999) == 0) do_reset();
            cycle(pend_v, pc, pl, ($urandom_range(0, 399) == 0), acc);
            if (acc) pend_v = 1'b0;
         end
      end
      wait_idle(3000);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
